serial_add_seq: RTL and testbench

Operand sequencer and result collector wrapped around the 4-bit bit-serial adder. Accepts operand pairs over a valid/ready handshake and holds them stable on the adder's parallel inputs. Pulses the adder's clear, waits a fixed number of adder cycles, captures the 4-bit sum, and presents it downstream over a second valid/ready handshake. It is the adder's only driver and only consumer.

---
 rtl/serial_add_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_serial_add_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq
// Operand sequencer and result collector for the 4-bit bit-serial adder.
// It accepts an operand pair, holds it on the adder inputs, and pulses the
// adder clear. It then waits ADD_CYCLES edges, captures the adder sum and
// offers that sum downstream.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer keeps its data stable while
// valid is high and ready is low. in_ready and out_valid are decodes of
// registered state only, so neither depends combinationally on in_valid or
// out_ready.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_a/in_b    operand pair input; in_ready accepts it (IDLE only)
//   adder_a/adder_b       registered operands driven to the adder
//   adder_clr             registered adder clear (high in IDLE and CLR)
//   adder_sum             sum returned by the adder
//   out_valid/out_sum     result output; out_ready accepts it
//   busy                  high whenever work is in flight
//   op_count              results handed downstream, wraps at 256
//   dbg_state             current FSM state, for observation
//
// Build option: define SERIAL_ADD_SEQ_QUEUE_EN to replace the single result
// register with a 2-entry result FIFO. The FSM then skips HOLD while the
// FIFO has room.
module serial_add_seq #(
    parameter int ADD_CYCLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       in_ready,
    output logic [3:0] adder_a,
    output logic [3:0] adder_b,
    output logic       adder_clr,
    input  logic [3:0] adder_sum,
    output logic       out_valid,
    output logic [3:0] out_sum,
    input  logic       out_ready,
    output logic       busy,
    output logic [7:0] op_count,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ADD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       clr_q, clr_d;
    logic [7:0] op_cnt_q, op_cnt_d;

    logic capture;    // sum sampled on this edge
    logic pop;        // result handed downstream on this edge
    logic to_hold;    // captured result cannot be stored yet
    logic hold_done;  // HOLD may be left on this edge

    assign capture = (state_q == S_RUN) && (cnt_q == LAST_CNT);
    assign pop     = out_valid && out_ready;

`ifdef SERIAL_ADD_SEQ_QUEUE_EN
    logic [3:0] fifo_q [2];
    logic [3:0] fifo_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic [3:0] pend_q, pend_d;   // result parked while the FIFO is full
    logic       full;
    logic       push;
    logic [3:0] push_data;

    assign full      = (count_q == 2'd2);
    // HOLD is only entered with a full FIFO, so any pop frees the slot we need.
    assign to_hold   = full;
    assign hold_done = pop;
    assign push      = (capture && !full) || ((state_q == S_HOLD) && pop);
    assign push_data = capture ? adder_sum : pend_q;

    assign out_valid = (count_q != 2'd0);
    assign out_sum   = fifo_q[rd_ptr_q];
    assign busy      = (state_q != S_IDLE) || (count_q != 2'd0);

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pend_d   = capture ? adder_sum : pend_q;
        if (push) begin
            fifo_d[wr_ptr_q] = push_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end
`else
    logic [3:0] res_q, res_d;
    logic       valid_q, valid_d;

    assign to_hold   = 1'b1;
    assign hold_done = pop;

    assign out_valid = valid_q;
    assign out_sum   = res_q;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        res_d   = res_q;
        valid_d = valid_q;
        if (capture) begin
            res_d   = adder_sum;
            valid_d = 1'b1;
        end
        if (pop) begin
            valid_d = 1'b0;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        clr_d    = clr_q;
        op_cnt_d = op_cnt_q;
        if (pop) begin
            op_cnt_d = op_cnt_q + 8'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    clr_d   = 1'b1;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                clr_d   = 1'b0;
                cnt_d   = 4'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + 4'd1;
                if (capture) begin
                    if (to_hold) begin
                        state_d = S_HOLD;
                    end else begin
                        clr_d   = 1'b1;   // adder is held cleared while idle
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (hold_done) begin
                    clr_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            clr_q    <= 1'b1;
            op_cnt_q <= 8'd0;
`ifdef SERIAL_ADD_SEQ_QUEUE_EN
            fifo_q[0] <= 4'd0;
            fifo_q[1] <= 4'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            pend_q    <= 4'd0;
`else
            res_q    <= 4'd0;
            valid_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            clr_q    <= clr_d;
            op_cnt_q <= op_cnt_d;
`ifdef SERIAL_ADD_SEQ_QUEUE_EN
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
`else
            res_q    <= res_d;
            valid_q  <= valid_d;
`endif
        end
    end

    // The in_ready decode is forced low while reset is held.
    assign in_ready  = (state_q == S_IDLE) && !reset;
    assign adder_a   = a_q;
    assign adder_b   = b_q;
    assign adder_clr = clr_q;
    assign op_count  = op_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Testbench for serial_add_seq (default build: single result register).
// A behavioural bit-serial adder closes the loop. Expected sums are computed
// directly as (a + b) mod 16 and queued on acceptance.
module tb_serial_add_seq;

    localparam int ADD_CYCLES = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       in_valid;
    logic [3:0] in_a, in_b;
    logic       in_ready;
    logic [3:0] adder_a, adder_b;
    logic       adder_clr;
    logic [3:0] adder_sum;
    logic       out_valid;
    logic [3:0] out_sum;
    logic       out_ready;
    logic       busy;
    logic [7:0] op_count;
    logic [1:0] dbg_state;

    serial_add_seq #(.ADD_CYCLES(ADD_CYCLES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .adder_a   (adder_a),
        .adder_b   (adder_b),
        .adder_clr (adder_clr),
        .adder_sum (adder_sum),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_ready (out_ready),
        .busy      (busy),
        .op_count  (op_count),
        .dbg_state (dbg_state)
    );

    // ---------------- bit-serial adder model ----------------
    logic [2:0] m_idx;
    logic       m_c;
    logic [3:0] m_sum;
    assign adder_sum = m_sum;

    always @(posedge clk) begin
        if (adder_clr) begin
            m_idx <= 3'd0;
            m_c   <= 1'b0;
            m_sum <= 4'd0;
        end else if (m_idx < 3'd4) begin
            m_sum[m_idx[1:0]] <= adder_a[m_idx[1:0]] ^ adder_b[m_idx[1:0]] ^ m_c;
            m_c <= (adder_a[m_idx[1:0]] & adder_b[m_idx[1:0]]) |
                   (m_c & (adder_a[m_idx[1:0]] ^ adder_b[m_idx[1:0]]));
            m_idx <= m_idx + 3'd1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    int         acc_q[$];
    logic [7:0] op_model = 8'd0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       prev_valid = 1'b0;
    logic       spacing_chk = 1'b0;
    int         last_acc = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor samples on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (acc_q.size() == 0) check("unexpected_valid", 32'(out_valid), 32'd0);
                else check("latency", 32'(cyc - acc_q.pop_front()), 32'(ADD_CYCLES + 1));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_result", 32'(out_valid), 32'd0);
                else check("sum", 32'(out_sum), 32'(exp_q.pop_front()));
                check("op_count_hs", 32'(op_count), 32'(op_model));
                op_model = op_model + 8'd1;
            end
            prev_valid = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Returns one cycle after the accept edge (DUT in CLR).
    task automatic send_op(input logic [3:0] a, input logic [3:0] b, input bit expect_res);
        int guard;
        int acc;
        guard    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        acc = cyc + 1;
        if (expect_res) begin
            exp_q.push_back(a + b);
            acc_q.push_back(acc);
        end
        if (spacing_chk && last_acc >= 0) check("spacing", 32'(acc - last_acc), 32'(ADD_CYCLES + 3));
        last_acc = acc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_chk_clr(input logic [3:0] a, input logic [3:0] b);
        send_op(a, b, 1'b1);
        check("clr_in_clr", 32'(adder_clr), 32'd1);
        check("busy_in_clr", 32'(busy), 32'd1);
        tick();
        check("clr_in_run", 32'(adder_clr), 32'd0);
        check("adder_a", 32'(adder_a), 32'(a));
        check("adder_b", 32'(adder_b), 32'(b));
    endtask

    task automatic drain;
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        acc_q.delete();
        op_model = 8'd0;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_adder_a", 32'(adder_a), 32'd0);
        check("rst_adder_b", 32'(adder_b), 32'd0);
        check("rst_adder_clr", 32'(adder_clr), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_state", 32'(dbg_state), 32'd0);

        // Basic op and carry discard.
        send_chk_clr(4'd3, 4'd5);
        drain();
        check("op_count_1", 32'(op_count), 32'd1);
        send_chk_clr(4'd9, 4'd9);
        drain();
        send_chk_clr(4'd15, 4'd1);
        drain();

        // Downstream stall: result held, new pairs ignored.
        out_ready = 1'b0;
        send_op(4'd7, 4'd6, 1'b1);
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 4'($urandom_range(0, 15));
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(out_sum), 32'hD);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("stall_adder_a", 32'(adder_a), 32'd7);
        out_ready = 1'b1;
        drain();
        check("op_count_4", 32'(op_count), 32'd4);

        // Reset three edges into RUN.
        send_op(4'd4, 4'd4, 1'b0);
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_clr", 32'(adder_clr), 32'd1);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        do_reset();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        send_chk_clr(4'd1, 4'd1);
        drain();

        // Input noise during RUN must not disturb the accepted pair.
        send_op(4'd6, 4'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 4'($urandom_range(0, 15));
            in_b     = 4'($urandom_range(0, 15));
            tick();
            check("noise_adder_a", 32'(adder_a), 32'd6);
            check("noise_adder_b", 32'(adder_b), 32'd7);
        end
        in_valid = 1'b0;
        drain();

        // 256 back-to-back ops: op_count wraps, spacing fixed.
        do_reset();
        spacing_chk = 1'b1;
        last_acc    = -1;
        for (int i = 0; i < 256; i++) begin
            send_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
        end
        spacing_chk = 1'b0;
        drain();
        check("wrap_op_count", 32'(op_count), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
